pcpi_coproc_dispatch: RTL and testbench

//  Parametrised PCPI front-end for the co-processor: decodes custom R-type instructions,

---
 rtl/pcpi_coproc_dispatch_if.sv | 39 +++
 rtl/pcpi_coproc_dispatch.sv | 170 +++++++++++++++++
 tb/tb_pcpi_coproc_dispatch.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcpi_coproc_dispatch_if.sv
// Signal bundle between picorv32's PCPI port, the co-processor dispatcher and its operation units.
// Handshakes: the CPU holds pico_valid until pico_ready pulses; the dispatcher holds u_stb until it
// samples u_busy high with it; a unit holds u_out_stb until the one-cycle u_out_busy acknowledge.
interface pcpi_coproc_dispatch_if #(
  parameter int XLEN      = 32,
  parameter int NUM_UNITS = 5,
  parameter int RES_W     = 16
);
  localparam int LW = XLEN / 2;

  logic                       pico_valid;
  logic [31:0]                pico_insn;
  logic [XLEN-1:0]            pico_rs1;
  logic [XLEN-1:0]            pico_rs2;
  logic                       pico_wr;
  logic [XLEN-1:0]            pico_rd;
  logic                       pico_wait;
  logic                       pico_ready;
  logic [LW-1:0]              u_a;
  logic [LW-1:0]              u_b;
  logic [LW-1:0]              u_c;
  logic [LW-1:0]              u_d;
  logic [NUM_UNITS-1:0]       u_stb;
  logic [NUM_UNITS-1:0]       u_busy;
  logic [NUM_UNITS*RES_W-1:0] u_res;
  logic [NUM_UNITS-1:0]       u_out_stb;
  logic [NUM_UNITS-1:0]       u_out_busy;

  // slave: the dispatcher itself; master: the CPU and unit environment around it
  modport slave (
    input  pico_valid, pico_insn, pico_rs1, pico_rs2, u_busy, u_res, u_out_stb,
    output pico_wr, pico_rd, pico_wait, pico_ready, u_a, u_b, u_c, u_d, u_stb, u_out_busy
  );

  modport master (
    output pico_valid, pico_insn, pico_rs1, pico_rs2, u_busy, u_res, u_out_stb,
    input  pico_wr, pico_rd, pico_wait, pico_ready, u_a, u_b, u_c, u_d, u_stb, u_out_busy
  );
endinterface

// File: rtl/pcpi_coproc_dispatch.sv
// PCPI front-end: claims custom R-type instructions, hands the operand lanes to the unit picked by
// funct3, waits for its result (with timeout and CPU-abort handling) and answers the CPU.
module pcpi_coproc_dispatch #(
  parameter int         XLEN      = 32,
  parameter int         NUM_UNITS = 5,
  parameter int         RES_W     = 16,
  parameter bit         RES_SEXT  = 1'b0,
  parameter logic [6:0] OPCODE    = 7'b0110011,
  parameter logic [6:0] FUNCT7    = 7'b0000001,
  parameter int         TIMEOUT   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pcpi_coproc_dispatch_if.slave bus,
  input  logic                  timeout_clr,
  output logic                  timeout_flag,
  output logic [1:0]            dbg_state
);
  localparam int LW = XLEN / 2;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EXEC, S_RESP} state_t;

  state_t               state;
  logic [2:0]           idx;
  logic [TW-1:0]        timer;
  logic                 guard;
  logic                 abort;
  logic                 drain;
  logic [NUM_UNITS-1:0] sel;
  logic [NUM_UNITS-1:0] new_sel;
  logic [RES_W-1:0]     sel_res;
  logic                 match;
  logic                 tmo;
  logic                 tmo_fire;
  logic                 out_hit;
  logic                 busy_hit;
  logic                 unused_insn;

  assign dbg_state   = state;
  assign unused_insn = ^{bus.pico_insn[24:15], bus.pico_insn[11:7]};
  assign sel         = NUM_UNITS'(1) << idx;
  assign new_sel     = NUM_UNITS'(1) << bus.pico_insn[14:12];
  assign match       = bus.pico_valid && (bus.pico_insn[6:0] == OPCODE) &&
                       (bus.pico_insn[31:25] == FUNCT7) &&
                       (int'(bus.pico_insn[14:12]) < NUM_UNITS) && !bus.pico_ready;
  assign tmo         = (TIMEOUT != 0) && (timer == T_LAST);
  assign out_hit     = |(bus.u_out_stb & sel);
  assign busy_hit    = |(bus.u_busy & bus.u_stb & sel);
  // A result arriving on the deadline cycle still wins over the timeout.
  assign tmo_fire    = tmo && (((state == S_ISSUE) && bus.pico_valid) ||
                               ((state == S_EXEC) && !out_hit));

  always_comb begin
    sel_res = '0;
    for (int k = 0; k < NUM_UNITS; k++)
      if (int'(idx) == k) sel_res = bus.u_res[k*RES_W +: RES_W];
  end

  function automatic logic [XLEN-1:0] extend(input logic [RES_W-1:0] r);
    logic [XLEN-1:0] x;
    x = '0;
    x[RES_W-1:0] = r;
    if (RES_SEXT && r[RES_W-1])
      for (int i = RES_W; i < XLEN; i++) x[i] = 1'b1;
    return x;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      idx            <= '0;
      timer          <= '0;
      guard          <= 1'b0;
      abort          <= 1'b0;
      drain          <= 1'b0;
      timeout_flag   <= 1'b0;
      bus.pico_wr    <= 1'b0;
      bus.pico_rd    <= '0;
      bus.pico_wait  <= 1'b0;
      bus.pico_ready <= 1'b0;
      bus.u_a        <= '0;
      bus.u_b        <= '0;
      bus.u_c        <= '0;
      bus.u_d        <= '0;
      bus.u_stb      <= '0;
      bus.u_out_busy <= '0;
    end else begin
      bus.pico_ready <= 1'b0;
      bus.pico_wr    <= 1'b0;
      bus.pico_rd    <= '0;
      bus.u_out_busy <= '0;
      if (tmo_fire)         timeout_flag <= 1'b1;
      else if (timeout_clr) timeout_flag <= 1'b0;

      case (state)
        S_IDLE: begin
          guard <= 1'b0;
          // A unit abandoned by a timeout may still answer; acknowledge and drop it.
          if (drain && out_hit) begin
            bus.u_out_busy <= sel;
            drain          <= 1'b0;
          end else if (match && !guard) begin
            bus.u_a       <= bus.pico_rs1[XLEN-1:LW];
            bus.u_b       <= bus.pico_rs1[LW-1:0];
            bus.u_c       <= bus.pico_rs2[XLEN-1:LW];
            bus.u_d       <= bus.pico_rs2[LW-1:0];
            bus.u_stb     <= new_sel;
            bus.pico_wait <= 1'b1;
            idx           <= bus.pico_insn[14:12];
            timer         <= '0;
            abort         <= 1'b0;
            drain         <= 1'b0;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= timer + 1'b1;
          if (!bus.pico_valid) begin
            bus.u_stb     <= '0;
            bus.pico_wait <= 1'b0;
            state         <= S_IDLE;
          end else if (tmo) begin
            bus.u_stb      <= '0;
            bus.pico_wait  <= 1'b0;
            bus.pico_ready <= 1'b1;
            state          <= S_RESP;
          end else if (busy_hit) begin
            bus.u_stb <= '0;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          timer <= timer + 1'b1;
          if (!bus.pico_valid) begin
            abort         <= 1'b1;
            bus.pico_wait <= 1'b0;
          end
          if (out_hit) begin
            bus.u_out_busy <= sel;
            if (abort || !bus.pico_valid) begin
              state <= S_IDLE;
            end else begin
              bus.pico_ready <= 1'b1;
              bus.pico_wr    <= 1'b1;
              bus.pico_rd    <= extend(sel_res);
              bus.pico_wait  <= 1'b0;
              state          <= S_RESP;
            end
          end else if (tmo) begin
            drain <= 1'b1;
            if (abort || !bus.pico_valid) begin
              state <= S_IDLE;
            end else begin
              bus.pico_ready <= 1'b1;
              bus.pico_wait  <= 1'b0;
              state          <= S_RESP;
            end
          end
        end
        S_RESP: begin
          guard <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pcpi_coproc_dispatch.sv
// Randomised bench for pcpi_coproc_dispatch: a zero-extending and a sign-extending instance share
// all stimulus; expected results come from a scoreboard fed by the issued instructions.
module tb_pcpi_coproc_dispatch;
  localparam int XLEN = 32;
  localparam int NU   = 5;
  localparam int RW   = 16;
  localparam int TMO  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tclr = 1'b0;
  logic       tflag0, tflag1;
  logic [1:0] dbg0, dbg1;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_s_q[$];

  always #5 clk = ~clk;

  pcpi_coproc_dispatch_if #(.XLEN(XLEN), .NUM_UNITS(NU), .RES_W(RW)) bus ();
  pcpi_coproc_dispatch_if #(.XLEN(XLEN), .NUM_UNITS(NU), .RES_W(RW)) bus_s ();

  assign bus_s.pico_valid = bus.pico_valid;
  assign bus_s.pico_insn  = bus.pico_insn;
  assign bus_s.pico_rs1   = bus.pico_rs1;
  assign bus_s.pico_rs2   = bus.pico_rs2;
  assign bus_s.u_busy     = bus.u_busy;
  assign bus_s.u_res      = bus.u_res;
  assign bus_s.u_out_stb  = bus.u_out_stb;

  pcpi_coproc_dispatch #(.XLEN(XLEN), .NUM_UNITS(NU), .RES_W(RW), .RES_SEXT(1'b0), .TIMEOUT(TMO)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus), .timeout_clr(tclr), .timeout_flag(tflag0), .dbg_state(dbg0)
  );
  pcpi_coproc_dispatch #(.XLEN(XLEN), .NUM_UNITS(NU), .RES_W(RW), .RES_SEXT(1'b1), .TIMEOUT(TMO)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus_s), .timeout_clr(tclr), .timeout_flag(tflag1), .dbg_state(dbg1)
  );

  // Operation-unit model: accepts the strobe, answers after unit_lat cycles, waits for the ack.
  int          unit_lat = 3;
  bit          unit_hang = 1'b0;
  bit          unit_refuse = 1'b0;
  logic [15:0] unit_res = '0;
  int          ph = 0;
  int          cnt = 0;
  int          act_k = 0;
  logic [NU-1:0] noise;

  always @(negedge clk) begin
    if (!rst_n) begin
      ph = 0;
      bus.u_busy = '0;
      bus.u_out_stb = '0;
      bus.u_res = '0;
    end else begin
      case (ph)
        0: if ((|bus.u_stb) && !unit_refuse) begin
          for (int k = 0; k < NU; k++) if (bus.u_stb[k]) act_k = k;
          bus.u_busy[act_k] = 1'b1;
          cnt = 0;
          ph = 1;
        end
        1: begin
          cnt++;
          if (cnt >= unit_lat && !unit_hang) begin
            for (int k = 0; k < NU; k++) bus.u_res[k*RW +: RW] = 16'($urandom);
            bus.u_res[act_k*RW +: RW] = unit_res;
            bus.u_out_stb = '0;
            bus.u_out_stb[act_k] = 1'b1;
            ph = 2;
          end else begin
            noise = NU'($urandom);
            noise[act_k] = 1'b0;
            bus.u_out_stb = noise;
          end
        end
        default: if (bus.u_out_busy[act_k]) begin
          bus.u_out_stb = '0;
          bus.u_busy = '0;
          ph = 0;
        end
      endcase
    end
  end

  task automatic drive_insn(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2);
    bus.pico_insn  = {7'b0000001, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b0110011};
    bus.pico_rs1   = rs1;
    bus.pico_rs2   = rs2;
    bus.pico_valid = 1'b1;
  endtask

  task automatic run_insn(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [15:0] res, input int lat);
    logic got;
    logic [31:0] e, es;
    unit_res = res;
    unit_lat = lat;
    @(negedge clk);
    drive_insn(f3, rs1, rs2);
    exp_q.push_back(32'(res));
    exp_s_q.push_back((res >= 16'h8000) ? 32'(res) + 32'hFFFF_0000 : 32'(res));
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = bus.pico_wait; end
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL claim: pico_wait got %b want 1", got); end
    n_vec++;
    if ({bus.u_a, bus.u_b, bus.u_c, bus.u_d} !== {16'(rs1 >> 16), 16'(rs1), 16'(rs2 >> 16), 16'(rs2)}) begin
      n_err++; $display("FAIL lanes: got %h want %h", {bus.u_a, bus.u_b, bus.u_c, bus.u_d},
                        {16'(rs1 >> 16), 16'(rs1), 16'(rs2 >> 16), 16'(rs2)});
    end
    n_vec++; if (bus.u_stb !== NU'(1 << f3)) begin n_err++; $display("FAIL u_stb: got %b want %b", bus.u_stb, NU'(1 << f3)); end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin @(negedge clk); got = bus.pico_ready; end
    e  = exp_q.pop_front();
    es = exp_s_q.pop_front();
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL ready: got %b want 1", got); end
    n_vec++; if (bus.pico_wr !== 1'b1) begin n_err++; $display("FAIL wr: got %b want 1", bus.pico_wr); end
    n_vec++; if (bus.pico_rd !== e) begin n_err++; $display("FAIL rd_zext: got %h want %h", bus.pico_rd, e); end
    n_vec++; if (bus_s.pico_rd !== es) begin n_err++; $display("FAIL rd_sext: got %h want %h", bus_s.pico_rd, es); end
    n_vec++; if (bus.u_out_busy !== NU'(1 << f3)) begin n_err++; $display("FAIL out_ack: got %b want %b", bus.u_out_busy, NU'(1 << f3)); end
    @(negedge clk);
    n_vec++;
    if ({bus.pico_ready, bus.pico_wr, bus.pico_rd, bus.u_out_busy} !== '0) begin
      n_err++; $display("FAIL pulse: got %b/%b/%h/%b want all 0", bus.pico_ready, bus.pico_wr, bus.pico_rd, bus.u_out_busy);
    end
    @(negedge clk);
    n_vec++; if ({bus.pico_wait, bus.u_stb} !== '0) begin n_err++; $display("FAIL guard: got wait=%b stb=%b want 0", bus.pico_wait, bus.u_stb); end
    bus.pico_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_vec++;
    if ({bus.pico_wait, bus.pico_ready, bus.pico_wr, bus.pico_rd, bus.u_a, bus.u_b, bus.u_c, bus.u_d,
         bus.u_stb, bus.u_out_busy, tflag0} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got wait=%b stb=%b flag=%b want 0", bus.pico_wait, bus.u_stb, tflag0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if ({bus.pico_wait, bus.u_stb, tflag0} !== '0) begin n_err++; $display("FAIL post_reset: got %b want 0", {bus.pico_wait, bus.u_stb, tflag0}); end
  endtask

  task automatic test_basic;
    run_insn(3'd0, 32'h0003_0004, 32'h0005_0006, 16'h8001, 3);
  endtask

  task automatic test_random;
    for (int n = 0; n < 20; n++)
      run_insn(3'($urandom_range(0, NU - 1)), $urandom, $urandom, 16'($urandom), $urandom_range(1, 5));
  endtask

  task automatic test_illegal;
    logic [31:0] tbl[5];
    int bad;
    tbl = '{{7'b0000001, 10'd0, 3'd5, 5'd1, 7'b0110011},
            {7'b0000001, 10'd0, 3'd6, 5'd1, 7'b0110011},
            {7'b0000001, 10'd0, 3'd7, 5'd1, 7'b0110011},
            {7'b0000000, 10'd0, 3'd0, 5'd1, 7'b0110011},
            {7'b0000001, 10'd0, 3'd0, 5'd1, 7'b0110111}};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.pico_insn = tbl[k];
      bus.pico_rs1 = $urandom;
      bus.pico_rs2 = $urandom;
      bus.pico_valid = 1'b1;
      bad = 0;
      repeat (20) begin
        @(negedge clk);
        if (bus.pico_wait || bus.pico_ready || (|bus.u_stb)) bad++;
      end
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL illegal_%0d: got %0d claimed cycles want 0", k, bad); end
      bus.pico_valid = 1'b0;
    end
  endtask

  task automatic test_abort_issue;
    logic got;
    int rdy;
    unit_refuse = 1'b1;
    @(negedge clk);
    drive_insn(3'd2, $urandom, $urandom);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = bus.pico_wait; end
    n_vec++; if (bus.u_stb !== 5'b00100) begin n_err++; $display("FAIL abort_issue_stb: got %b want 00100", bus.u_stb); end
    bus.pico_valid = 1'b0;
    @(negedge clk);
    n_vec++; if ({bus.u_stb, bus.pico_wait} !== '0) begin n_err++; $display("FAIL abort_issue_drop: got %b want 0", {bus.u_stb, bus.pico_wait}); end
    rdy = 0;
    repeat (5) begin @(negedge clk); if (bus.pico_ready) rdy++; end
    n_vec++; if (rdy != 0) begin n_err++; $display("FAIL abort_issue_ready: got %0d want 0", rdy); end
    unit_refuse = 1'b0;
    run_insn(3'd3, $urandom, $urandom, 16'($urandom), 2);
  endtask

  task automatic test_abort_exec;
    logic got;
    int ack, rdy;
    unit_lat = 6;
    @(negedge clk);
    drive_insn(3'd4, $urandom, $urandom);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = bus.pico_wait; end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = (bus.u_stb == '0); end
    bus.pico_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.pico_wait !== 1'b0) begin n_err++; $display("FAIL abort_exec_wait: got %b want 0", bus.pico_wait); end
    ack = 0; rdy = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.u_out_busy[4]) ack++;
      if (bus.pico_ready || bus.pico_wr) rdy++;
    end
    n_vec++; if (ack != 1) begin n_err++; $display("FAIL abort_exec_ack: got %0d acks want 1", ack); end
    n_vec++; if (rdy != 0) begin n_err++; $display("FAIL abort_exec_ready: got %0d want 0", rdy); end
  endtask

  task automatic test_timeout(input bit hold_clr);
    logic got;
    int cnt, ack;
    logic [2:0] f3;
    f3 = 3'($urandom_range(0, NU - 1));
    unit_hang = 1'b1;
    tclr = hold_clr;
    @(negedge clk);
    drive_insn(f3, $urandom, $urandom);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = bus.pico_wait; end
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL tmo_claim: got %b want 1", got); end
    cnt = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin @(negedge clk); cnt++; got = bus.pico_ready; end
    n_vec++; if (cnt != TMO) begin n_err++; $display("FAIL tmo_latency: got %0d want %0d", cnt, TMO); end
    n_vec++;
    if ({got, bus.pico_wr, bus.pico_rd} !== {1'b1, 1'b0, 32'h0}) begin
      n_err++; $display("FAIL tmo_resp: got ready=%b wr=%b rd=%h want 1/0/0", got, bus.pico_wr, bus.pico_rd);
    end
    n_vec++; if (tflag0 !== 1'b1) begin n_err++; $display("FAIL tmo_flag_set: got %b want 1", tflag0); end
    @(negedge clk);
    bus.pico_valid = 1'b0;
    if (!hold_clr) repeat (4) @(negedge clk);
    n_vec++;
    if (tflag0 !== (hold_clr ? 1'b0 : 1'b1)) begin
      n_err++; $display("FAIL tmo_flag_after: got %b want %b", tflag0, (hold_clr ? 1'b0 : 1'b1));
    end
    unit_hang = 1'b0;
    ack = 0;
    repeat (20) begin @(negedge clk); if (bus.u_out_busy[f3]) ack++; end
    n_vec++; if (ack != 1) begin n_err++; $display("FAIL tmo_drain_ack: got %0d acks want 1", ack); end
    tclr = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic got;
    unit_lat = 10;
    @(negedge clk);
    drive_insn(3'd0, $urandom, $urandom);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = bus.pico_wait; end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.pico_wait, bus.pico_ready, bus.pico_rd, bus.u_a, bus.u_b, bus.u_c, bus.u_d,
         bus.u_stb, bus.u_out_busy, tflag0} !== '0) begin
      n_err++; $display("FAIL reset_mid: got wait=%b lanes=%h flag=%b want 0", bus.pico_wait,
                        {bus.u_a, bus.u_b, bus.u_c, bus.u_d}, tflag0);
    end
    bus.pico_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_insn(3'd1, $urandom, $urandom, 16'($urandom), 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pico_valid = 1'b0;
    bus.pico_insn  = '0;
    bus.pico_rs1   = '0;
    bus.pico_rs2   = '0;
    test_reset();
    test_basic();
    test_random();
    test_illegal();
    test_abort_issue();
    test_abort_exec();
    test_timeout(1'b0);
    test_reset_mid();
    test_timeout(1'b1);
    test_basic();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
